// File: rtl/mul_radix4_seq.sv
// Iterative radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Optional MUL_ZERO_BYPASS_EN: a zero operand at accept goes straight to DONE with result 0.
module mul_radix4_seq #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             yumi_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [1:0]       state_dbg
);

  // Handshakes: a request transfers on a cycle with valid_in & ready_o & !flush_i;
  // a result transfers on a cycle with valid_o & yumi_i, and valid_o/result_o/tag_o
  // stay stable until then.

  localparam int EW   = WIDTH + 2;
  localparam int ITER = EW / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] FINAL_CNT = CW'(ITER);
  localparam logic [CW-1:0] LAST_STEP = CW'(ITER - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [EW-1:0]        a_q;
  logic [EW:0]          m_q;
  logic [2*WIDTH+1:0]   p_q;
  logic [1:0]           op_q;
  logic [TAG_W-1:0]     tag_q;

  logic                 accept;
  logic                 zero_op;
  logic [EW-1:0]        a_ext, b_ext;
  logic [EW+1:0]        a_w, pp, sum;
  logic [2*WIDTH+3:0]   p_wide;
  logic [2*WIDTH+1:0]   p_next;
  logic [EW:0]          m_next;
  logic [WIDTH-1:0]     result_sel;

  assign ready_o   = (state_q == IDLE) && !reset;
  assign valid_o   = (state_q == DONE);
  assign state_dbg = state_q;
  assign accept    = valid_in && ready_o && !flush_i;
  assign zero_op   = (a_i == '0) || (b_i == '0);

  // Only MULHU treats rs1 as unsigned; only MUL/MULH treat rs2 as signed.
  assign a_ext = (op_i == OP_MULHU) ? {2'b00, a_i} : {{2{a_i[WIDTH-1]}}, a_i};
  assign b_ext = (op_i == OP_MUL || op_i == OP_MULH) ? {{2{b_i[WIDTH-1]}}, b_i}
                                                    : {2'b00, b_i};

  always_comb begin
    a_w = {{2{a_q[EW-1]}}, a_q};
    pp  = '0;
    case (m_q[2:0])
      3'b001, 3'b010: pp = a_w;
      3'b011:         pp = a_w << 1;
      3'b100:         pp = -(a_w << 1);
      3'b101, 3'b110: pp = -a_w;
      default:        pp = '0;
    endcase
    sum    = {{2{p_q[2*WIDTH+1]}}, p_q[2*WIDTH+1:WIDTH]} + pp;
    p_wide = {sum, p_q[WIDTH-1:0]};
    // The final step adds without shifting so the product lands at bit 0.
    p_next = (cnt_q == LAST_STEP) ? p_wide[2*WIDTH+1:0] : p_wide[2*WIDTH+3:2];
    m_next = {{2{m_q[EW]}}, m_q[EW:2]};
    result_sel = (op_q == OP_MUL) ? p_q[WIDTH-1:0] : p_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MUL_ZERO_BYPASS_EN
          state_d = zero_op ? DONE : BUSY;
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY:    if (cnt_q == FINAL_CNT) state_d = DONE;
      DONE:    if (yumi_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      m_q      <= '0;
      p_q      <= '0;
      op_q     <= '0;
      tag_q    <= '0;
      result_o <= '0;
      tag_o    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= a_ext;
        m_q   <= {b_ext, 1'b0};
        p_q   <= '0;
        cnt_q <= '0;
        op_q  <= op_i;
        tag_q <= tag_i;
`ifdef MUL_ZERO_BYPASS_EN
        if (zero_op) begin
          result_o <= '0;
          tag_o    <= tag_i;
        end
`endif
      end else if (state_q == BUSY && !flush_i) begin
        if (cnt_q == FINAL_CNT) begin
          result_o <= result_sel;
          tag_o    <= tag_q;
        end else begin
          p_q   <= p_next;
          m_q   <= m_next;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // zero_op only steers the bypass path; keep it referenced in the default build.
  logic unused_zero;
  assign unused_zero = zero_op;

endmodule

// File: tb/tb_mul_radix4_seq.sv
// Self-checking bench for mul_radix4_seq: vector table, scoreboard queue, flush/reset corners.
module tb_mul_radix4_seq;

  localparam int W     = 32;
  localparam int TW    = 6;
  localparam int LAT   = 18;
`ifdef MUL_ZERO_BYPASS_EN
  localparam int ZLAT  = 0;
`else
  localparam int ZLAT  = 18;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic          ready_o;
  logic [W-1:0]  a_i, b_i;
  logic [1:0]    op_i;
  logic [TW-1:0] tag_i;
  logic          flush_i;
  logic          valid_o;
  logic          yumi_i;
  logic [W-1:0]  result_o;
  logic [TW-1:0] tag_o;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  exp_q[$];
  logic [TW-1:0] tag_q[$];

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic [TW-1:0] tag;
    logic [W-1:0]  exp;
  } vec_t;

  vec_t vecs[16];

  mul_radix4_seq #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .op_i(op_i), .tag_i(tag_i), .flush_i(flush_i),
    .valid_o(valid_o), .yumi_i(yumi_i), .result_o(result_o), .tag_o(tag_o),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    logic signed [65:0] sa, sb, p;
    sa = (op == 2'b11) ? {34'd0, a} : {{34{a[W-1]}}, a};
    sb = (op == 2'b00 || op == 2'b01) ? {{34{b[W-1]}}, b} : {34'd0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic [TW-1:0] tag, input logic [W-1:0] exp, input int hold,
                        input string name);
    int lat;
    logic [W-1:0]  e;
    logic [TW-1:0] et;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    check({name, "_ready"}, ready_o, 1);
    valid_in = 1'b1; a_i = a; b_i = b; op_i = op; tag_i = tag;
    @(posedge clk); #1;
    valid_in = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 2'($urandom_range(0, 3)); tag_i = TW'($urandom);
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, lat, (a == 0 || b == 0) ? ZLAT : LAT);
    if (valid_o) begin
      e  = exp_q.pop_front();
      et = tag_q.pop_front();
      check({name, "_res"}, result_o, e);
      check({name, "_tag"}, tag_o, et);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({name, "_hold_valid"}, valid_o, 1);
        check({name, "_hold_res"}, result_o, e);
        check({name, "_hold_ready"}, ready_o, 0);
      end
      yumi_i = 1'b1;
      @(posedge clk); #1;
      yumi_i = 1'b0;
      check({name, "_after_yumi_valid"}, valid_o, 0);
      check({name, "_after_yumi_ready"}, ready_o, 1);
    end else begin
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
    end
  endtask

  initial begin
    int seen;
    vecs[0] = '{32'd7,         32'd6,         2'b00, 6'd5,  32'd42};
    vecs[1] = '{32'h80000000,  32'h80000000,  2'b01, 6'd1,  32'h40000000};
    vecs[2] = '{32'h80000000,  32'h80000000,  2'b00, 6'd2,  32'h00000000};
    vecs[3] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  2'b11, 6'd3,  32'hFFFFFFFE};
    vecs[4] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  2'b01, 6'd4,  32'h00000000};
    vecs[5] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  2'b10, 6'd6,  32'hFFFFFFFF};
    vecs[6] = '{32'hFFFFFFF9,  32'd6,         2'b00, 6'd7,  32'hFFFFFFD6};
    vecs[7] = '{32'd0,         32'd12345,     2'b00, 6'd8,  32'd0};
    vecs[8] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  2'b01, 6'd9,  32'h3FFFFFFF};
    vecs[9] = '{32'h80000000,  32'hFFFFFFFF,  2'b10, 6'd10, 32'h80000000};
    for (int i = 10; i < 16; i++) begin
      vecs[i].a   = $urandom;
      vecs[i].b   = $urandom;
      vecs[i].op  = 2'($urandom_range(0, 3));
      vecs[i].tag = TW'($urandom_range(0, 63));
      vecs[i].exp = model(vecs[i].a, vecs[i].b, vecs[i].op);
    end

    reset = 1'b1; valid_in = 1'b0; a_i = '0; b_i = '0; op_i = '0; tag_i = '0;
    flush_i = 1'b0; yumi_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_tag", tag_o, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", ready_o, 1);

    for (int i = 0; i < 16; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, vecs[i].exp, 0,
             $sformatf("vec%0d", i));

    run_op(32'hFFFFFFF9, 32'd6, 2'b00, 6'd11, 32'hFFFFFFD6, 10, "hold");

    valid_in = 1'b1; a_i = 32'd5; b_i = 32'd9; op_i = 2'b00; tag_i = 6'd12;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_ready", ready_o, 1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (valid_o) seen++;
      @(posedge clk); #1;
    end
    check("flush_no_valid", seen, 0);
    run_op(32'd3, 32'd3, 2'b00, 6'd13, 32'd9, 0, "after_flush");

    valid_in = 1'b1; flush_i = 1'b1; a_i = 32'd4; b_i = 32'd4; op_i = 2'b00;
    @(posedge clk); #1;
    valid_in = 1'b0; flush_i = 1'b0;
    check("flush_vs_valid_state", state_dbg, 0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (valid_o) seen++;
      @(posedge clk); #1;
    end
    check("flush_vs_valid_no_result", seen, 0);

    valid_in = 1'b1; a_i = 32'd100; b_i = 32'd200; op_i = 2'b00; tag_i = 6'd14;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready", ready_o, 0);
    reset = 1'b0;
    #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_result", result_o, 0);
    check("midrst_tag", tag_o, 0);
    check("midrst_ready_after", ready_o, 1);
    run_op(32'hDEADBEEF, 32'h12345678, 2'b11, 6'd15,
           model(32'hDEADBEEF, 32'h12345678, 2'b11), 0, "after_midrst");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
